axi_ad9371_tx_datagen: RTL and testbench
========================================

AXI_AD9371_TX_DATAGEN -- requirements
Module: axi_ad9371_tx_datagen

Interface
REQ-001 SHALL have parameter DATAPATH_DISABLE, default 0; when 1, DMA passthrough only and pattern logic is removed.
REQ-002 SHALL have port dac_clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port dac_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port dac_valid  input  1  link sample strobe; one 64-bit frame per asserted cycle.
REQ-005 SHALL have port dac_enable_i0 / dac_enable_q0  input  1 each  channel enable.
REQ-006 SHALL have port dac_data_sel_i0 / dac_data_sel_q0  input  3 each  source select: 0 DMA, 1 constant, 2 ramp, 3 PN7, 4 PN15, 5-7 reserved.
REQ-007 SHALL have port dac_const_i0 / dac_const_q0  input  32 each  constant pattern word.
REQ-008 SHALL have port dac_valid_i0 / dac_valid_q0  output  1 each  DMA read strobe.
REQ-009 SHALL have port dac_data_i0 / dac_data_q0  input  32 each  DMA data, valid in the same cycle as the read strobe.
REQ-010 SHALL have port dac_dunf  input  1  DMA underflow flag.
REQ-011 SHALL have port dac_unf_clr  input  1  clear for the underflow counter.
REQ-012 SHALL have port dac_data  output  64  frame: [31:0] I, [63:32] Q; each 32-bit word is two 16-bit samples, sample0 in [15:0].
REQ-013 SHALL have port dac_valid_out  output  1  registered copy of dac_valid aligned with dac_data.
REQ-014 SHALL have port dac_unf_count  output  16  saturating underflow count.

Function
REQ-015 dac_valid_x0 SHALL be combinational: dac_valid & dac_enable_x0 & (sel==0 or DATAPATH_DISABLE==1).
REQ-016 dac_data and dac_valid_out SHALL be registered with 1-cycle latency from dac_valid.
REQ-017 When dac_valid is 0, dac_data SHALL hold and no generator SHALL advance.
REQ-018 A disabled channel SHALL output 0x00000000 on valid cycles, and its generators SHALL hold.
REQ-019 Constant source: channel word SHALL equal dac_const_x0, sampled on the valid cycle.
REQ-020 Ramp: sample0 SHALL be n and sample1 SHALL be n+1, with n advancing by 2 per valid and wrapping mod 2^16; n starts at 0.
REQ-021 PN7 (x^7+x^6+1) and PN15 (x^15+x^14+1) SHALL be Fibonacci LFSRs seeded all-ones that advance 32 bits per valid cycle.
REQ-022 PN bit order: the first generated bit SHALL land in bit 15 of sample0, continuing MSB-first through sample0 and then sample1.
REQ-023 An all-zero LFSR state SHALL be reloaded with all-ones on the next valid cycle.
REQ-024 Any change of dac_data_sel_x0 SHALL restart that channel's ramp at 0 and reseed its PN state on the following cycle; the other channel SHALL be unaffected.
REQ-025 Reserved select codes SHALL output zero.
REQ-026 Underflow: on a valid cycle with dac_dunf=1, every enabled DMA-selected channel SHALL output zero.
REQ-027 The underflow counter SHALL increment once per such cycle if at least one channel is affected, saturating at 0xFFFF.
REQ-028 dac_unf_clr SHALL zero the counter and SHALL take priority over a simultaneous increment.
REQ-029 With DATAPATH_DISABLE=1, select inputs SHALL be ignored and both channels SHALL behave as DMA-selected.

Reset
REQ-030 While dac_rst=1: dac_data=0, dac_valid_out=0, dac_valid_x0=0, dac_unf_count=0, ramp=0, LFSRs all-ones.
REQ-031 Reset asserted mid-stream SHALL take effect at the next edge; the first valid after release SHALL produce ramp 0x0001_0000 and a fresh PN seed.

Structure
REQ-032 Select codes, PN polynomials and seeds SHALL live in shared package axi_ad9371_tx_pkg.
REQ-033 The per-channel generator SHALL be sub-module axi_ad9371_tx_datagen_channel, instantiated twice.
REQ-034 The underflow counter and output register SHALL reside in the top module.

Verification
REQ-035 Reset, then sel_i0=2, enable, 3 valids -> I words 0x0001_0000, 0x0003_0002, 0x0005_0004 at 1-cycle latency.
REQ-036 Ramp run 32769 valids -> sample0 wraps 0xFFFE -> 0x0000, no glitch on Q.
REQ-037 sel=3/4, 1000 valids with random valid gaps -> bits match bench PN7/PN15 model; sel toggle 3->1->3 reseeds (first word identical to post-reset first word).
REQ-038 sel=0, DMA data 0x1234_5678, dunf pulsed 3 valid cycles -> dac_valid_i0 high each valid, output zero for those 3 frames, count=3.
REQ-039 Count preloaded to 0xFFFF via forced underflows -> stays 0xFFFF; dac_unf_clr with dunf same cycle -> count 0.
REQ-040 dac_rst pulsed mid-PN15 stream -> outputs zero during reset; first post-reset frame equals seed-derived first word.

Source files
------------

// File: rtl/axi_ad9371_tx_pkg.sv
// axi_ad9371_tx_pkg: shared select codes, PN polynomials, seeds and the
// 32-bit-per-step Fibonacci LFSR helper used by the TX data generator.
package axi_ad9371_tx_pkg;

    typedef enum logic [2:0] {
        SEL_DMA   = 3'd0,
        SEL_CONST = 3'd1,
        SEL_RAMP  = 3'd2,
        SEL_PN7   = 3'd3,
        SEL_PN15  = 3'd4
    } dac_sel_e;

    // Taps mark x^N and x^(N-1) of a left-shifting Fibonacci register;
    // the feedback bit is also the emitted bit.
    localparam logic [15:0] PN7_TAPS  = 16'h0060;
    localparam logic [15:0] PN7_MASK  = 16'h007F;
    localparam logic [15:0] PN7_SEED  = 16'h007F;
    localparam logic [15:0] PN15_TAPS = 16'h6000;
    localparam logic [15:0] PN15_MASK = 16'h7FFF;
    localparam logic [15:0] PN15_SEED = 16'h7FFF;

    localparam logic [15:0] UNF_CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic [15:0] state;
        logic [31:0] word;
    } pn_step_t;

    // Runs the LFSR 32 steps. The first bit emitted ends up in bit 15
    // of sample0; bits fill sample0 MSB-first, then sample1.
    function automatic pn_step_t pn_run32(
        input logic [15:0] seed,
        input logic [15:0] taps,
        input logic [15:0] mask
    );
        pn_step_t    r;
        logic [15:0] s;
        logic [15:0] s0;
        logic [15:0] s1;
        logic        fb;
        s  = seed;
        s0 = '0;
        s1 = '0;
        for (int k = 0; k < 32; k++) begin
            fb = ^(s & taps);
            s  = {s[14:0], fb} & mask;
            if (k < 16) s0 = {s0[14:0], fb};
            else        s1 = {s1[14:0], fb};
        end
        r.state = s;
        r.word  = {s1, s0};
        return r;
    endfunction

endpackage

// File: rtl/axi_ad9371_tx_datagen_channel.sv
// axi_ad9371_tx_datagen_channel: one I or Q channel source (DMA, const,
// ramp, PN7, PN15). Ports: i_clk/i_rst, i_valid strobe, i_enable, i_sel,
// i_const, i_dma_data, i_dunf in; o_dma_rd, o_unf, o_word (comb) out.
module axi_ad9371_tx_datagen_channel
    import axi_ad9371_tx_pkg::*;
#(
    parameter int DATAPATH_DISABLE = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_enable,
    input  logic [2:0]  i_sel,
    input  logic [31:0] i_const,
    input  logic [31:0] i_dma_data,
    input  logic        i_dunf,
    output logic        o_dma_rd,
    output logic        o_unf,
    output logic [31:0] o_word
);

    logic        w_dma_sel;
    logic [31:0] w_gen_word;

    generate
        if (DATAPATH_DISABLE != 0) begin : g_dma_only
            assign w_dma_sel  = 1'b1;
            assign w_gen_word = '0;
        end else begin : g_pattern
            logic [15:0] r_ramp;
            logic [15:0] r_pn7;
            logic [15:0] r_pn15;
            logic [2:0]  r_sel_prev;
            logic        w_chg;
            logic        w_adv;
            logic [15:0] w_ramp;
            logic [15:0] w_pn7;
            logic [15:0] w_pn15;
            pn_step_t    w_p7;
            pn_step_t    w_p15;

            // A select change restarts the generators; using the seed
            // as the current state makes the first new word clean even
            // when the change lands on a valid cycle.
            assign w_chg  = (i_sel != r_sel_prev);
            assign w_adv  = i_valid & i_enable;
            assign w_ramp = w_chg ? 16'h0000 : r_ramp;
            assign w_pn7  = (w_chg || r_pn7 == 16'h0000) ?
                            PN7_SEED : r_pn7;
            assign w_pn15 = (w_chg || r_pn15 == 16'h0000) ?
                            PN15_SEED : r_pn15;
            assign w_p7   = pn_run32(w_pn7, PN7_TAPS, PN7_MASK);
            assign w_p15  = pn_run32(w_pn15, PN15_TAPS, PN15_MASK);
            assign w_dma_sel = (i_sel == SEL_DMA);

            always_comb begin
                w_gen_word = '0;
                case (i_sel)
                    SEL_CONST: w_gen_word = i_const;
                    SEL_RAMP:  w_gen_word = {w_ramp + 16'd1, w_ramp};
                    SEL_PN7:   w_gen_word = w_p7.word;
                    SEL_PN15:  w_gen_word = w_p15.word;
                    default:   w_gen_word = '0;
                endcase
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_ramp     <= '0;
                    r_pn7      <= PN7_SEED;
                    r_pn15     <= PN15_SEED;
                    r_sel_prev <= SEL_DMA;
                end else begin
                    r_sel_prev <= i_sel;
                    r_ramp     <= w_ramp;
                    r_pn7      <= w_pn7;
                    r_pn15     <= w_pn15;
                    if (w_adv) begin
                        case (i_sel)
                            SEL_RAMP: r_ramp <= w_ramp + 16'd2;
                            SEL_PN7:  r_pn7  <= w_p7.state;
                            SEL_PN15: r_pn15 <= w_p15.state;
                            default:  ;
                        endcase
                    end
                end
            end
        end
    endgenerate

    assign o_dma_rd = i_valid & i_enable & w_dma_sel & ~i_rst;
    assign o_unf    = o_dma_rd & i_dunf;

    always_comb begin
        o_word = '0;
        if (i_enable) begin
            if (w_dma_sel) o_word = i_dunf ? 32'h0 : i_dma_data;
            else           o_word = w_gen_word;
        end
    end

endmodule

// File: rtl/axi_ad9371_tx_datagen.sv
// axi_ad9371_tx_datagen: two-channel TX frame generator with output
// register and saturating DMA underflow counter. Ports: dac_clk/dac_rst,
// dac_valid, per-channel enable/sel/const/DMA in, dac_valid_i0/q0 DMA
// strobes out, dac_dunf/dac_unf_clr in, dac_data/dac_valid_out/
// dac_unf_count out.
module axi_ad9371_tx_datagen
    import axi_ad9371_tx_pkg::*;
#(
    parameter int DATAPATH_DISABLE = 0
) (
    input  logic        dac_clk,
    input  logic        dac_rst,
    input  logic        dac_valid,
    input  logic        dac_enable_i0,
    input  logic        dac_enable_q0,
    input  logic [2:0]  dac_data_sel_i0,
    input  logic [2:0]  dac_data_sel_q0,
    input  logic [31:0] dac_const_i0,
    input  logic [31:0] dac_const_q0,
    output logic        dac_valid_i0,
    output logic        dac_valid_q0,
    input  logic [31:0] dac_data_i0,
    input  logic [31:0] dac_data_q0,
    input  logic        dac_dunf,
    input  logic        dac_unf_clr,
    output logic [63:0] dac_data,
    output logic        dac_valid_out,
    output logic [15:0] dac_unf_count
);

    logic [31:0] w_word_i;
    logic [31:0] w_word_q;
    logic        w_unf_i;
    logic        w_unf_q;
    logic [63:0] r_data;
    logic        r_valid_out;
    logic [15:0] r_unf_cnt;

    axi_ad9371_tx_datagen_channel #(
        .DATAPATH_DISABLE (DATAPATH_DISABLE)
    ) u_ch_i (
        .i_clk      (dac_clk),
        .i_rst      (dac_rst),
        .i_valid    (dac_valid),
        .i_enable   (dac_enable_i0),
        .i_sel      (dac_data_sel_i0),
        .i_const    (dac_const_i0),
        .i_dma_data (dac_data_i0),
        .i_dunf     (dac_dunf),
        .o_dma_rd   (dac_valid_i0),
        .o_unf      (w_unf_i),
        .o_word     (w_word_i)
    );

    axi_ad9371_tx_datagen_channel #(
        .DATAPATH_DISABLE (DATAPATH_DISABLE)
    ) u_ch_q (
        .i_clk      (dac_clk),
        .i_rst      (dac_rst),
        .i_valid    (dac_valid),
        .i_enable   (dac_enable_q0),
        .i_sel      (dac_data_sel_q0),
        .i_const    (dac_const_q0),
        .i_dma_data (dac_data_q0),
        .i_dunf     (dac_dunf),
        .o_dma_rd   (dac_valid_q0),
        .o_unf      (w_unf_q),
        .o_word     (w_word_q)
    );

    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            r_data      <= '0;
            r_valid_out <= 1'b0;
            r_unf_cnt   <= '0;
        end else begin
            r_valid_out <= dac_valid;
            if (dac_valid) r_data <= {w_word_q, w_word_i};
            // Clear wins over a coincident underflow.
            if (dac_unf_clr)
                r_unf_cnt <= '0;
            else if ((w_unf_i | w_unf_q) && r_unf_cnt != UNF_CNT_MAX)
                r_unf_cnt <= r_unf_cnt + 16'd1;
        end
    end

    assign dac_data      = r_data;
    assign dac_valid_out = r_valid_out;
    assign dac_unf_count = r_unf_cnt;

endmodule

// File: tb/tb_axi_ad9371_tx_datagen.sv
// tb_axi_ad9371_tx_datagen: randomized and directed stimulus checked
// every cycle against a sequence-based behavioural model.
module tb_axi_ad9371_tx_datagen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid;
    logic        en_i;
    logic        en_q;
    logic [2:0]  sel_i;
    logic [2:0]  sel_q;
    logic [31:0] cst_i;
    logic [31:0] cst_q;
    logic [31:0] dma_i;
    logic [31:0] dma_q;
    logic        dunf;
    logic        clr;
    logic        rd_i;
    logic        rd_q;
    logic [63:0] data;
    logic        vo;
    logic [15:0] cnt;

    axi_ad9371_tx_datagen dut (
        .dac_clk         (clk),
        .dac_rst         (rst),
        .dac_valid       (valid),
        .dac_enable_i0   (en_i),
        .dac_enable_q0   (en_q),
        .dac_data_sel_i0 (sel_i),
        .dac_data_sel_q0 (sel_q),
        .dac_const_i0    (cst_i),
        .dac_const_q0    (cst_q),
        .dac_valid_i0    (rd_i),
        .dac_valid_q0    (rd_q),
        .dac_data_i0     (dma_i),
        .dac_data_q0     (dma_q),
        .dac_dunf        (dunf),
        .dac_unf_clr     (clr),
        .dac_data        (data),
        .dac_valid_out   (vo),
        .dac_unf_count   (cnt)
    );

    int checks   = 0;
    int failures = 0;
    int prints   = 0;
    bit chk_en   = 1'b0;

    // Full PN bit sequences, one period each, starting from the seed.
    bit seq7[127];
    bit seq15[32767];

    int          m_n[2];
    int          m_i7[2];
    int          m_i15[2];
    logic [2:0]  m_prev[2];
    logic [63:0] e_data;
    logic        e_vo;
    logic [15:0] e_cnt;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (prints < 40) begin
                prints++;
                $display("FAIL %s actual=%h required=%h", name, act, exp);
            end
        end
    endtask

    // b[k] = b[k-N] ^ b[k-N+1], with the bits before k=0 all ones.
    function automatic void build_seq();
        for (int k = 0; k < 127; k++) begin
            bit a;
            bit b;
            a = (k >= 7) ? seq7[k-7] : 1'b1;
            b = (k >= 6) ? seq7[k-6] : 1'b1;
            seq7[k] = a ^ b;
        end
        for (int k = 0; k < 32767; k++) begin
            bit a;
            bit b;
            a = (k >= 15) ? seq15[k-15] : 1'b1;
            b = (k >= 14) ? seq15[k-14] : 1'b1;
            seq15[k] = a ^ b;
        end
    endfunction

    function automatic logic [31:0] pn_word(input bit is15, input int idx);
        logic [15:0] s0;
        logic [15:0] s1;
        bit          b;
        s0 = '0;
        s1 = '0;
        for (int j = 0; j < 32; j++) begin
            b = is15 ? seq15[(idx + j) % 32767] : seq7[(idx + j) % 127];
            if (j < 16) s0 = {s0[14:0], b};
            else        s1 = {s1[14:0], b};
        end
        return {s1, s0};
    endfunction

    function automatic logic [31:0] model_chan(
        input int ch, input bit en, input logic [2:0] sel,
        input logic [31:0] cst, input logic [31:0] dma,
        input bit v, input bit uf);
        logic [31:0] w;
        logic [15:0] n;
        if (sel != m_prev[ch]) begin
            m_n[ch]   = 0;
            m_i7[ch]  = 0;
            m_i15[ch] = 0;
        end
        m_prev[ch] = sel;
        n = 16'(m_n[ch]);
        w = '0;
        if (en) begin
            case (sel)
                3'd0:    w = uf ? 32'h0 : dma;
                3'd1:    w = cst;
                3'd2:    w = {n + 16'd1, n};
                3'd3:    w = pn_word(1'b0, m_i7[ch]);
                3'd4:    w = pn_word(1'b1, m_i15[ch]);
                default: w = '0;
            endcase
        end
        if (v && en) begin
            case (sel)
                3'd2:    m_n[ch]   = (m_n[ch] + 2) % 65536;
                3'd3:    m_i7[ch]  = (m_i7[ch] + 32) % 127;
                3'd4:    m_i15[ch] = (m_i15[ch] + 32) % 32767;
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic model_step();
        logic [31:0] wi;
        logic [31:0] wq;
        bit          hit;
        if (rst) begin
            e_data = '0;
            e_vo   = 1'b0;
            e_cnt  = '0;
            for (int c = 0; c < 2; c++) begin
                m_n[c]   = 0;
                m_i7[c]  = 0;
                m_i15[c] = 0;
            end
            m_prev[0] = sel_i;
            m_prev[1] = sel_q;
        end else begin
            wi = model_chan(0, en_i, sel_i, cst_i, dma_i, valid, dunf);
            wq = model_chan(1, en_q, sel_q, cst_q, dma_q, valid, dunf);
            if (valid) e_data = {wq, wi};
            e_vo = valid;
            hit = valid && dunf &&
                  ((en_i && sel_i == 3'd0) || (en_q && sel_q == 3'd0));
            if (clr) e_cnt = '0;
            else if (hit && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("dac_data", data, e_data);
            check("dac_valid_out", 64'(vo), 64'(e_vo));
            check("dac_unf_count", 64'(cnt), 64'(e_cnt));
            check("dac_valid_i0", 64'(rd_i),
                  64'(!rst && valid && en_i && sel_i == 3'd0));
            check("dac_valid_q0", 64'(rd_q),
                  64'(!rst && valid && en_q && sel_q == 3'd0));
        end
    end

    initial begin
        int nv;
        build_seq();
        rst = 1'b1; valid = 1'b0; en_i = 1'b0; en_q = 1'b0;
        sel_i = 3'd0; sel_q = 3'd0; cst_i = '0; cst_q = '0;
        dma_i = '0; dma_q = '0; dunf = 1'b0; clr = 1'b0;
        e_data = '0; e_vo = 1'b0; e_cnt = '0;
        step();
        chk_en = 1'b1;
        step();
        check("reset_data", data, 64'h0);
        check("reset_cnt", 64'(cnt), 64'h0);

        // DMA passthrough and underflow zeroing.
        rst = 1'b0; en_i = 1'b1; sel_i = 3'd0; dma_i = 32'h1234_5678;
        en_q = 1'b1; sel_q = 3'd1; cst_q = 32'hA5A5_0F0F; valid = 1'b1;
        step();
        check("dma_pass", 64'(data[31:0]), 64'h1234_5678);
        check("const_q", 64'(data[63:32]), 64'hA5A5_0F0F);
        dunf = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("unf_zero", 64'(data[31:0]), 64'h0);
        end
        valid = 1'b0;
        step();
        dunf = 1'b0;
        step();
        check("unf_count3", 64'(cnt), 64'd3);

        // Ramp on I through wrap; Q DMA in continuous underflow.
        rst = 1'b1;
        step();
        rst = 1'b0; sel_i = 3'd2; en_i = 1'b1;
        sel_q = 3'd0; en_q = 1'b1; dunf = 1'b1; valid = 1'b1;
        for (int k = 0; k < 32769; k++) begin
            dma_q = $urandom;
            step();
            if (k == 0) check("ramp0", 64'(data[31:0]), 64'h0001_0000);
            if (k == 1) check("ramp1", 64'(data[31:0]), 64'h0003_0002);
            if (k == 2) check("ramp2", 64'(data[31:0]), 64'h0005_0004);
            if (k == 32767)
                check("ramp_top", 64'(data[31:0]), 64'hFFFF_FFFE);
            if (k == 32768)
                check("ramp_wrap", 64'(data[31:0]), 64'h0001_0000);
        end
        check("unf_count_mid", 64'(cnt), 64'h8001);
        for (int k = 0; k < 32770; k++) step();
        check("unf_sat", 64'(cnt), 64'hFFFF);
        clr = 1'b1;
        step();
        check("unf_clr_prio", 64'(cnt), 64'h0);
        clr = 1'b0; dunf = 1'b0;

        // PN7 on I, PN15 on Q with random valid gaps.
        rst = 1'b1;
        step();
        rst = 1'b0; sel_i = 3'd3; sel_q = 3'd4; valid = 1'b1;
        step();
        check("pn7_first", 64'(data[31:0]), 64'h28F2_020C);
        check("pn15_first", 64'(data[63:32]), 64'h000C_0002);
        nv = 0;
        for (int k = 0; k < 3000 && nv < 1000; k++) begin
            valid = ($urandom_range(0, 2) != 0);
            if (valid) nv++;
            step();
        end
        valid = 1'b1; sel_i = 3'd1; cst_i = $urandom;
        step();
        valid = 1'b0;
        step();
        sel_i = 3'd3; valid = 1'b1;
        step();
        check("pn7_reseed", 64'(data[31:0]), 64'h28F2_020C);

        // Reset in the middle of the PN15 stream.
        for (int k = 0; k < 5; k++) step();
        rst = 1'b1;
        step();
        check("rst_mid_data", data, 64'h0);
        check("rst_mid_vo", 64'(vo), 64'h0);
        step();
        rst = 1'b0;
        step();
        check("rst_pn15_first", 64'(data[63:32]), 64'h000C_0002);
        check("rst_pn7_first", 64'(data[31:0]), 64'h28F2_020C);

        // Fully random mix.
        for (int k = 0; k < 3000; k++) begin
            rst   = ($urandom_range(0, 99) == 0);
            valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) sel_i = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) sel_q = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) en_i = ~en_i;
            if ($urandom_range(0, 31) == 0) en_q = ~en_q;
            cst_i = $urandom; cst_q = $urandom;
            dma_i = $urandom; dma_q = $urandom;
            dunf  = ($urandom_range(0, 3) == 0);
            clr   = ($urandom_range(0, 31) == 0);
            step();
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
